int_to_float_seq: RTL and testbench

Multi-cycle signed/unsigned 32-bit integer to IEEE-754 single-precision converter (FCVT.S.W / FCVT.S.WU direction), the inverse of the FALU's float-to-integer path. It sits beside the FALU in the RV32IM pipeline FPU. Operands are accepted over a valid/ready handshake, normalized one bit per cycle, rounded round-to-nearest-even, and the result is held on a valid/ready output port.

---
 rtl/int_to_float_seq_if.sv | 23 ++
 rtl/int_to_float_seq.sv | 117 +++++++++++
 tb/tb_int_to_float_seq.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/int_to_float_seq_if.sv
// Valid/ready operand and result ports of the integer-to-single converter.
interface int_to_float_seq_if;
  localparam int unsigned DATA_W = 32;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_signed;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_inexact;

  modport master (
    output in_valid, in_data, in_signed, out_ready,
    input  in_ready, out_valid, out_data, out_inexact
  );

  modport slave (
    input  in_valid, in_data, in_signed, out_ready,
    output in_ready, out_valid, out_data, out_inexact
  );
endinterface

// File: rtl/int_to_float_seq.sv
// Multi-cycle int32/uint32 to IEEE-754 single converter: one normalising
// shift per cycle, round-to-nearest-even, result held until accepted.
module int_to_float_seq (
  input  logic               clk,
  input  logic               reset,
  int_to_float_seq_if.slave  bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(158);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mag_q, mag_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic                sign_q, sign_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                inexact_q, inexact_d;
  logic                valid_q, valid_d;

  logic                accept;
  logic                in_sign;
  logic [DATA_W-1:0]   in_mag;
  logic                guard_bit;
  logic                sticky_bit;
  logic                round_up;
  logic [FRAC_W:0]     frac_sum;
  logic [EXP_W-1:0]    exp_rnd;

  assign bus.in_ready    = (state_q == IDLE) && !reset;
  assign bus.out_valid   = valid_q;
  assign bus.out_data    = data_q;
  assign bus.out_inexact = inexact_q;

  assign accept  = bus.in_valid && bus.in_ready;
  assign in_sign = bus.in_signed & bus.in_data[DATA_W-1];
  assign in_mag  = in_sign ? (~bus.in_data + DATA_W'(1)) : bus.in_data;

  // Rounding datapath on the normalised magnitude (leading one at bit 31)
  assign guard_bit  = mag_q[7];
  assign sticky_bit = |mag_q[6:0];
  assign round_up   = guard_bit && (sticky_bit || mag_q[8]);
  assign frac_sum   = {1'b0, mag_q[30:8]} + (FRAC_W+1)'(round_up);
  assign exp_rnd    = exp_q + EXP_W'(frac_sum[FRAC_W]);

  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    exp_d     = exp_q;
    sign_d    = sign_q;
    data_d    = data_q;
    inexact_d = inexact_q;
    valid_d   = valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sign_d = in_sign;
          mag_d  = in_mag;
          exp_d  = EXP_TOP;
          if (in_mag == '0) begin
            // Zero spends one pass through ROUND, which leaves the +0 intact
            data_d    = '0;
            inexact_d = 1'b0;
            state_d   = ROUND;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (!mag_q[DATA_W-1]) begin
          mag_d = mag_q << 1;
          exp_d = exp_q - EXP_W'(1);
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (mag_q != '0) begin
          data_d    = {sign_q, exp_rnd, frac_sum[FRAC_W-1:0]};
          inexact_d = guard_bit | sticky_bit;
        end
        valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mag_q     <= '0;
      exp_q     <= '0;
      sign_q    <= 1'b0;
      data_q    <= '0;
      inexact_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      exp_q     <= exp_d;
      sign_q    <= sign_d;
      data_q    <= data_d;
      inexact_q <= inexact_d;
      valid_q   <= valid_d;
    end
  end
endmodule

// File: tb/tb_int_to_float_seq.sv
// Directed vector bench for int_to_float_seq: values, inexact flag, latency,
// reset abort and output backpressure.
module tb_int_to_float_seq;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int_to_float_seq_if bus ();

  int_to_float_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        sgn;
    logic [31:0] exp_data;
    logic        exp_inex;
    int          exp_lat;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one operand, wait for the accept, then count cycles to out_valid
  task automatic run_op(input logic [31:0] d, input logic s,
                        output logic [31:0] od, output logic oi, output int lat);
    int wait_n;
    od  = '0;
    oi  = 1'b0;
    lat = -1;
    @(negedge clk);
    bus.in_data   = d;
    bus.in_signed = s;
    bus.in_valid  = 1'b1;
    wait_n = 0;
    while (!bus.in_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = n;
        od  = bus.out_data;
        oi  = bus.out_inexact;
        break;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] od;
    logic        oi;
    int          lat;
    int          spur;

    vecs[0]  = '{32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 1'b0, 33};
    vecs[1]  = '{32'h0000_0001, 1'b0, 32'h3F80_0000, 1'b0, 33};
    vecs[2]  = '{32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1};
    vecs[3]  = '{32'h8000_0000, 1'b1, 32'hCF00_0000, 1'b0, 2};
    vecs[4]  = '{32'h8000_0000, 1'b0, 32'h4F00_0000, 1'b0, 2};
    vecs[5]  = '{32'h0100_0001, 1'b0, 32'h4B80_0000, 1'b1, 9};
    vecs[6]  = '{32'h0100_0003, 1'b0, 32'h4B80_0002, 1'b1, 9};
    vecs[7]  = '{32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 1'b1, 2};
    vecs[8]  = '{32'h0000_0003, 1'b0, 32'h4040_0000, 1'b0, 32};
    vecs[9]  = '{32'h8000_0001, 1'b1, 32'hCF00_0000, 1'b1, 3};
    vecs[10] = '{32'h0000_0005, 1'b1, 32'h40A0_0000, 1'b0, 31};
    vecs[11] = '{32'h00FF_FFFF, 1'b0, 32'h4B7F_FFFF, 1'b0, 10};
    vecs[12] = '{32'hFFFF_FFFE, 1'b1, 32'hC000_0000, 1'b0, 32};
    vecs[13] = '{32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_signed = 1'b0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_out_inexact", 32'(bus.out_inexact), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].data, vecs[i].sgn, od, oi, lat);
      check($sformatf("v%0d_data", i), od, vecs[i].exp_data);
      check($sformatf("v%0d_inexact", i), 32'(oi), 32'(vecs[i].exp_inex));
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Reset in the middle of normalising operand 1 aborts it
    @(negedge clk);
    bus.in_data   = 32'h0000_0001;
    bus.in_signed = 1'b0;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("abort%0d_out_valid", c), 32'(bus.out_valid), 32'd0);
      check($sformatf("abort%0d_out_data", c), bus.out_data, 32'd0);
      check($sformatf("abort%0d_in_ready", c), 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_in_ready_after", 32'(bus.in_ready), 32'd1);
    spur = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) spur++;
    end
    check("abort_no_spurious", 32'(spur), 32'd0);

    // Backpressure: result held while out_ready is low and a new operand waits
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_data   = 32'h0000_0001;
    bus.in_signed = 1'b0;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_data = 32'h0000_0003;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = n;
        break;
      end
    end
    check("bp_latency", 32'(lat), 32'd33);
    check("bp_data", bus.out_data, 32'h3F80_0000);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d_valid", c), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp_hold%0d_data", c), bus.out_data, 32'h3F80_0000);
      check($sformatf("bp_hold%0d_in_ready", c), 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_after_hs_valid", 32'(bus.out_valid), 32'd0);
    check("bp_after_hs_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp_after_hs_data_held", bus.out_data, 32'h3F80_0000);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_next_accepted", 32'(bus.in_ready), 32'd0);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      if (bus.out_valid) begin
        lat = n - 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("bp_next_latency", 32'(lat), 32'd32);
    check("bp_next_data", bus.out_data, 32'h4040_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
